// File: rtl/ps2_kbd_pkg.sv
// Types and constants for the Scan Code Set 2 keyboard decoder.
// Holds the event record, the prefix FSM states and the special byte values.
package ps2_kbd_pkg;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic       pause;
  } kbd_event_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } kbd_state_t;

  localparam logic [7:0] SC_EXT       = 8'hE0;
  localparam logic [7:0] SC_BRK       = 8'hF0;
  localparam logic [7:0] SC_PAUSE     = 8'hE1;
  localparam logic [7:0] ST_BAT_OK    = 8'hAA;
  localparam logic [7:0] ST_BAT_FAIL  = 8'hFC;
  localparam logic [7:0] ST_ACK       = 8'hFA;
  localparam logic [7:0] ST_RESEND    = 8'hFE;
  localparam logic [7:0] ST_KBD_ERR0  = 8'h00;
  localparam logic [7:0] ST_KBD_ERR1  = 8'hFF;

  localparam int         PAUSE_LEN    = 7;
  localparam logic [7:0] PAUSE_CODE   = 8'h77;

endpackage

// File: rtl/ps2_pkg.sv
// Shared types of the PS/2 controller layer.
// Only the receive error flags are needed by the keyboard decoder.
package ps2_pkg;

  typedef struct packed {
    logic parity_err;
    logic frame_err;
    logic timeout;
  } flags_t;

endpackage

// File: rtl/ps2_kbd_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module ps2_kbd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  T            mem [DEPTH];
  logic        do_pop;
  logic        do_push;

  // A push into a full FIFO still succeeds when the head leaves in the same cycle.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// Scan Code Set 2 decoder: folds E0/F0/E1 prefixes into one event per keystroke,
// buffers events in a FIFO and reports device status bytes as one-cycle pulses.
module ps2_kbd_decoder
  import ps2_pkg::*;
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  flags_t               rx_flags,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output kbd_event_t           ev,
  output logic                 bat_ok,
  output logic                 bat_fail,
  output logic                 ack,
  output logic                 resend,
  output logic                 kbd_err,
  output logic                 ovf,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int                   CNT_W   = $clog2(PAUSE_LEN);
  localparam logic [CNT_W-1:0]     CNT_END = CNT_W'(PAUSE_LEN - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  kbd_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             emit;
  kbd_event_t       ev_in;
  kbd_event_t       head;
  logic             proto_err;
  logic             err_inc;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             bat_ok_nx, bat_fail_nx, ack_nx, resend_nx, kbd_err_nx;

  assign pop      = ev_valid && ev_ready;
  assign ev_valid = !fifo_empty;
  assign ev       = ev_valid ? head : '0;
  assign err_inc  = (en && rx_valid && (rx_flags != '0)) || proto_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Prefix tracking: only a clean byte sampled while enabled moves the FSM.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    emit        = 1'b0;
    ev_in       = '0;
    proto_err   = 1'b0;
    bat_ok_nx   = 1'b0;
    bat_fail_nx = 1'b0;
    ack_nx      = 1'b0;
    resend_nx   = 1'b0;
    kbd_err_nx  = 1'b0;
    if (!en) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
    end else if (rx_valid) begin
      if (rx_flags != '0) begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end else begin
        ev_in.code = rx_data;
        case (state)
          S_IDLE: begin
            case (rx_data)
              SC_EXT:                   state_nx = S_EXT;
              SC_BRK:                   state_nx = S_BRK;
              SC_PAUSE: begin
                state_nx = S_PAUSE;
                cnt_nx   = '0;
              end
              ST_BAT_OK:                bat_ok_nx   = 1'b1;
              ST_BAT_FAIL:              bat_fail_nx = 1'b1;
              ST_ACK:                   ack_nx      = 1'b1;
              ST_RESEND:                resend_nx   = 1'b1;
              ST_KBD_ERR0, ST_KBD_ERR1: kbd_err_nx  = 1'b1;
              default:                  emit        = 1'b1;
            endcase
          end
          S_EXT: begin
            case (rx_data)
              SC_BRK:   state_nx  = S_EXT_BRK;
              SC_EXT:   proto_err = 1'b1;
              SC_PAUSE: begin
                state_nx = S_PAUSE;
                cnt_nx   = '0;
              end
              default: begin
                emit      = 1'b1;
                ev_in.ext = 1'b1;
                state_nx  = S_IDLE;
              end
            endcase
          end
          S_BRK: begin
            case (rx_data)
              SC_BRK:   proto_err = 1'b1;
              SC_EXT: begin
                proto_err = 1'b1;
                state_nx  = S_EXT;
              end
              SC_PAUSE: begin
                state_nx = S_PAUSE;
                cnt_nx   = '0;
              end
              default: begin
                emit      = 1'b1;
                ev_in.brk = 1'b1;
                state_nx  = S_IDLE;
              end
            endcase
          end
          S_EXT_BRK: begin
            case (rx_data)
              SC_EXT, SC_BRK: proto_err = 1'b1;
              SC_PAUSE: begin
                state_nx = S_PAUSE;
                cnt_nx   = '0;
              end
              default: begin
                emit      = 1'b1;
                ev_in.brk = 1'b1;
                ev_in.ext = 1'b1;
                state_nx  = S_IDLE;
              end
            endcase
          end
          S_PAUSE: begin
            // The pause sequence carries no useful content; only its length matters.
            if (cnt == CNT_END) begin
              emit        = 1'b1;
              ev_in       = '0;
              ev_in.code  = PAUSE_CODE;
              ev_in.pause = 1'b1;
              state_nx    = S_IDLE;
              cnt_nx      = '0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
          default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bat_ok   <= 1'b0;
      bat_fail <= 1'b0;
      ack      <= 1'b0;
      resend   <= 1'b0;
      kbd_err  <= 1'b0;
    end else begin
      bat_ok   <= bat_ok_nx;
      bat_fail <= bat_fail_nx;
      ack      <= ack_nx;
      resend   <= resend_nx;
      kbd_err  <= kbd_err_nx;
    end
  end

  // ovf is cleared by disabling the block; err_cnt survives everything but reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf     <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (!en)                             ovf <= 1'b0;
      else if (emit && fifo_full && !pop)  ovf <= 1'b1;
      if (err_inc && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + 1'b1;
    end
  end

  ps2_kbd_fifo #(
    .DEPTH (DEPTH),
    .T     (kbd_event_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (!en),
    .push  (emit),
    .din   (ev_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: doc/ps2_kbd_decoder.md
Name: ps2_kbd_decoder

Overview:
- Downstream consumer of ps2_controller. Takes the received byte stream (rx_data/valid/flags) and decodes PS/2 Scan Code Set 2 prefixes (E0, F0, E1 pause) into one key event per keystroke.
- Events are buffered in a small FIFO with a ready/valid output towards the application (CPU-visible keyboard port).
- Device status bytes (BAT, ACK, resend, keyboard error) are reported as single-cycle pulses and never enter the FIFO.

Parameters:
- DEPTH, 4, event FIFO depth in entries; power of two, >= 2.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous active-high reset.
- en  in  1  enable. Low: flush FIFO, FSM to IDLE, ignore inputs, clear ovf.
- rx_valid  in  1  byte strobe from ps2_controller valid; one cycle per byte.
- rx_data  in  8  received byte, qualified by rx_valid.
- rx_flags  in  ps2_pkg::flags_t  controller error flags, qualified by rx_valid; any bit set means the byte is bad.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head when ev_valid && ev_ready.
- ev  out  ps2_kbd_pkg::kbd_event_t  head event {code[7:0], brk, ext, pause}.
- bat_ok  out  1  pulse: 0xAA received.
- bat_fail  out  1  pulse: 0xFC received.
- ack  out  1  pulse: 0xFA received.
- resend  out  1  pulse: 0xFE received.
- kbd_err  out  1  pulse: 0x00 or 0xFF received (keyboard buffer overrun).
- ovf  out  1  sticky: an event was dropped because the FIFO was full.
- err_cnt  out  ERR_CNT_W  saturating count of flagged bytes plus protocol errors.

Behaviour:
- Reset: ev_valid=0, ev=0, all pulses=0, ovf=0, err_cnt=0, FSM=IDLE, FIFO empty.
- A byte is consumed only at an edge where en && rx_valid are both high.
- Flagged byte (|rx_flags): byte discarded, FSM to IDLE, err_cnt+1. This applies in every state, including PAUSE.
- Status bytes 0xAA/0xFC/0xFA/0xFE/0x00/0xFF are recognised only in IDLE:
  - the matching pulse is high for exactly the one cycle after the edge;
  - no event is produced; FSM stays IDLE.
  - In any other state the same values are treated as scan codes.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
  - IDLE: E0->EXT; F0->BRK; E1->PAUSE with cnt=0; other byte -> emit {code,brk=0,ext=0}.
  - EXT: F0->EXT_BRK; E0->stay EXT (protocol error, err_cnt+1); E1->PAUSE; other -> emit {code,0,1}, go IDLE.
  - BRK: F0->stay BRK (err+1); E0->EXT (err+1); E1->PAUSE; other -> emit {code,1,0}, go IDLE.
  - EXT_BRK: E0/F0 -> stay (err+1); E1->PAUSE; other -> emit {code,1,1}, go IDLE.
  - PAUSE: swallow the next 7 bytes regardless of value. After the 7th byte, emit {code=0x77, brk=0, ext=0, pause=1} and go IDLE.
- Emit/latency: the event is written into the FIFO at the same edge that samples the final byte. ev_valid is high from the following cycle (registered FIFO, first-word fall-through), so latency is 1 cycle.
- FIFO:
  - Pop on ev_valid && ev_ready.
  - Push with full && pop in the same cycle: both occur, no drop.
  - Push with full && !pop: event dropped, ovf set, FSM still advances.
  - Pointers wrap modulo DEPTH; an extra bit distinguishes full from empty.
- err_cnt saturates at 2^ERR_CNT_W-1 and is cleared only by rst.
- en falling mid-sequence (e.g. after E0): the prefix is discarded. The FIFO flush is synchronous, and ev_valid is low the cycle after en is sampled low.

Decomposition:
- Package ps2_kbd_pkg holds:
  - kbd_event_t;
  - state enum;
  - byte constants SC_EXT=E0, SC_BRK=F0, SC_PAUSE=E1, ST_BAT_OK=AA, ST_BAT_FAIL=FC, ST_ACK=FA, ST_RESEND=FE;
  - PAUSE_LEN=7, PAUSE_CODE=0x77.
- Sub-module ps2_kbd_fifo: generic synchronous FWFT FIFO, parameterised on DEPTH and element type, with push/pop/full/empty ports.

Test Plan:
- Bytes 1C, then F0 1C, ev_ready=1 -> events {1C,brk0,ext0} then {1C,brk1,ext0}; each ev_valid one cycle after the final byte.
- E0 75, E0 F0 75 -> {75,0,1} then {75,1,1}; no pulses; err_cnt=0.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event {77,pause=1}, emitted after the 8th byte.
- AA, FA, 00 in IDLE -> bat_ok, ack, kbd_err each one cycle; FIFO stays empty. Then E0 with rx_flags!=0, then 1C -> err_cnt=1, event {1C,0,0}: the prefix is lost.
- ev_ready=0, 5 make codes 15,16,17,18,19 with DEPTH=4 -> 4 events held and ovf=1. Draining yields 15..18 in order. A push and pop in the same cycle while full must not set ovf again after it is cleared by toggling en.
- F0 received, then en=0 for 1 cycle, then en=1 and 1C -> {1C,brk0}; FIFO empty while en was low.
